// File: rtl/pdm_pkg.sv
// Shared definitions for the PDM-to-PCM CIC decimator.
//   CIC_ORDER  : number of integrator/comb pairs (3).
//   cic_width  : accumulator width needed for a given log2 decimation ratio.
//   comb_state_t : sequencing of the time-shared comb subtractor.
//   cic_scale  : clamp the unsigned CIC result and map it to signed PCM.
package pdm_pkg;

  localparam int CIC_ORDER = 3;

  function automatic int cic_width(input int decim_log2);
    return CIC_ORDER * decim_log2 + 1;
  endfunction

  typedef enum logic [2:0] {
    IDLE,
    C1,
    C2,
    C3,
    OUT
  } comb_state_t;

  // r is the unsigned CIC result (0..R^3, acc_w bits used). The only value
  // with bit acc_w-1 set is exactly R^3, which is clamped to R^3-1 so that a
  // full-scale input lands on the largest positive code instead of wrapping.
  // The top out_w bits of the remaining fraction are kept (zero-padded on the
  // right for small ratios), and the MSB is inverted to go from offset binary
  // to two's complement.
  function automatic logic [31:0] cic_scale(input logic [63:0] r,
                                            input int acc_w,
                                            input int out_w);
    logic [63:0] frac;
    logic [63:0] scaled;
    int          frac_w;
    frac_w = acc_w - 1;
    frac   = r & ((64'd1 << frac_w) - 64'd1);
    if (r[frac_w]) frac = (64'd1 << frac_w) - 64'd1;
    if (frac_w >= out_w) scaled = frac >> (frac_w - out_w);
    else                 scaled = frac << (out_w - frac_w);
    scaled[out_w-1] = ~scaled[out_w-1];
    return scaled[31:0];
  endfunction

endpackage

// File: rtl/cic_integrator.sv
// One modular CIC integrator: acc accumulates the zero-extended addend every
// clock and wraps silently at 2^ACC_W.
//   clk, rst : clock, asynchronous active-high reset
//   addend   : IN_W-bit unsigned input (previous stage or the PDM bit)
//   acc      : ACC_W-bit running sum
module cic_integrator #(
  parameter int IN_W  = 1,
  parameter int ACC_W = 34
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IN_W-1:0]  addend,
  output logic [ACC_W-1:0] acc
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) acc <= '0;
    else     acc <= acc + ACC_W'(addend);
  end

endmodule

// File: rtl/pdm_decimator.sv
// 3rd-order CIC decimator turning a 1-bit density stream into signed PCM.
//   clk, rst      : clock, asynchronous active-high reset
//   data_in       : 1-bit density stream (1 counts as one, 0 as zero)
//   sample        : signed OUT_W-bit PCM sample
//   sample_valid  : sample holds a new, unconsumed value
//   sample_ready  : consumer takes sample on a cycle with sample_valid high
//   overrun       : sticky, a pending sample was overwritten
//   overrun_clr   : single-cycle clear of overrun (a same-cycle overrun wins)
module pdm_decimator
  import pdm_pkg::*;
#(
  parameter int DECIM_LOG2 = 11,
  parameter int OUT_W      = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    data_in,
  output logic signed [OUT_W-1:0] sample,
  output logic                    sample_valid,
  input  logic                    sample_ready,
  output logic                    overrun,
  input  logic                    overrun_clr
);

  localparam int W = cic_width(DECIM_LOG2);

  logic [W-1:0] integ1, integ2, integ3;

  cic_integrator #(.IN_W(1), .ACC_W(W)) u_int1 (
    .clk(clk), .rst(rst), .addend(data_in), .acc(integ1));
  cic_integrator #(.IN_W(W), .ACC_W(W)) u_int2 (
    .clk(clk), .rst(rst), .addend(integ1), .acc(integ2));
  cic_integrator #(.IN_W(W), .ACC_W(W)) u_int3 (
    .clk(clk), .rst(rst), .addend(integ2), .acc(integ3));

  // Decimation: tick on the last count of each frame; the snapshot takes the
  // value integ3 is being updated to on that same edge.
  logic [DECIM_LOG2-1:0] decim_cnt;
  logic                  tick;
  logic [W-1:0]          snap;

  assign tick = (decim_cnt == '1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      decim_cnt <= '0;
      snap      <= '0;
    end else begin
      decim_cnt <= decim_cnt + DECIM_LOG2'(1);
      if (tick) snap <= integ3 + integ2;
    end
  end

  // Comb FSM: one shared subtractor walks the three comb stages.
  comb_state_t state, state_next;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (tick) state_next = C1;
      C1:      state_next = C2;
      C2:      state_next = C3;
      C3:      state_next = OUT;
      OUT:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  logic [W-1:0] dly1, dly2, dly3, stage_val;
  logic [W-1:0] comb_in, comb_dly, comb_diff;

  always_comb begin
    comb_in  = stage_val;
    comb_dly = dly3;
    case (state)
      C1: begin
        comb_in  = snap;
        comb_dly = dly1;
      end
      C2:      comb_dly = dly2;
      default: comb_dly = dly3;
    endcase
    comb_diff = comb_in - comb_dly;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dly1      <= '0;
      dly2      <= '0;
      dly3      <= '0;
      stage_val <= '0;
    end else begin
      case (state)
        C1: begin
          dly1      <= comb_in;
          stage_val <= comb_diff;
        end
        C2: begin
          dly2      <= comb_in;
          stage_val <= comb_diff;
        end
        C3: begin
          dly3      <= comb_in;
          stage_val <= comb_diff;
        end
        default: ;
      endcase
    end
  end

  // Output stage: the first three results only prime the comb delays.
  logic [1:0]       warm;
  logic             load;
  logic             transfer;
  logic [OUT_W-1:0] scaled;

  assign load     = (state == OUT) && (warm == 2'd3);
  assign transfer = sample_valid && sample_ready;
  assign scaled   = OUT_W'(cic_scale(64'(stage_val), W, OUT_W));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      warm         <= '0;
      sample       <= '0;
      sample_valid <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      if (state == OUT && warm != 2'd3) warm <= warm + 2'd1;
      if (load) begin
        sample       <= scaled;
        sample_valid <= 1'b1;
      end else if (transfer) begin
        sample_valid <= 1'b0;
      end
      if (load && sample_valid && !sample_ready) overrun <= 1'b1;
      else if (overrun_clr)                      overrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pdm_decimator.sv
// Directed bench for pdm_decimator: constant/alternating density vectors on
// the default ratio, handshake/overrun and asynchronous reset sequences, and
// a random stream on a small-ratio instance against a reference CIC model.
module tb_pdm_decimator;

  localparam int  R    = 2048;
  localparam int  SR   = 16;
  localparam int  SW   = 13;
  localparam longint SMASK = (longint'(1) << SW) - 1;
  localparam longint SFULL = longint'(SR) * SR * SR;

  logic               clk = 1'b0;
  logic               rst, data_in, sample_ready, overrun_clr;
  logic signed [15:0] sample;
  logic               sample_valid, overrun;

  logic               rst_s, data_s;
  logic signed [15:0] sample_s;
  logic               valid_s, overrun_s;

  int vectors = 0;
  int errors  = 0;
  int cyc     = 0;
  int pat     = 0;
  bit mdl_upd = 0;
  bit mdl_chk = 0;

  longint m_i1, m_i2, m_i3, m_d1, m_d2, m_d3;
  int     m_cnt, m_warm;
  longint exp_q[$];

  typedef struct {
    int pat;
    int exp_sample;
  } vec_t;
  vec_t tbl[3];

  pdm_decimator u_dut (
    .clk(clk), .rst(rst), .data_in(data_in), .sample(sample),
    .sample_valid(sample_valid), .sample_ready(sample_ready),
    .overrun(overrun), .overrun_clr(overrun_clr));

  pdm_decimator #(.DECIM_LOG2(4), .OUT_W(16)) u_small (
    .clk(clk), .rst(rst_s), .data_in(data_s), .sample(sample_s),
    .sample_valid(valid_s), .sample_ready(1'b1),
    .overrun(overrun_s), .overrun_clr(1'b0));

  always #5 clk = ~clk;

  task automatic check(input string name, input longint act, input longint exp);
    vectors++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference CIC for the small instance: integrators advance on every edge
  // using the previous stage's old value; on the last count of a frame the
  // freshly updated third integrator is differenced three times.
  task automatic model_edge(input longint d);
    longint s, y1, y2, y3, c;
    if (m_cnt == SR - 1) begin
      s  = (m_i3 + m_i2) & SMASK;
      y1 = (s - m_d1) & SMASK;  m_d1 = s;
      y2 = (y1 - m_d2) & SMASK; m_d2 = y1;
      y3 = (y2 - m_d3) & SMASK; m_d3 = y2;
      if (m_warm == 3) begin
        c = (y3 >= SFULL) ? SFULL - 1 : y3;
        exp_q.push_back(c * 16 - 32768);
      end else begin
        m_warm++;
      end
    end
    m_i3  = (m_i3 + m_i2) & SMASK;
    m_i2  = (m_i2 + m_i1) & SMASK;
    m_i1  = (m_i1 + d) & SMASK;
    m_cnt = (m_cnt + 1) % SR;
  endtask

  task automatic step();
    if (mdl_upd) model_edge(longint'(data_s));
    @(posedge clk);
    cyc++;
    #1;
    case (pat)
      0:       data_in = 1'b0;
      1:       data_in = 1'b1;
      2:       data_in = ~data_in;
      default: ;
    endcase
    if (mdl_upd) data_s = 1'($urandom_range(0, 1));
    if (mdl_chk && valid_s) begin
      if (exp_q.size() == 0) check("rand_unexpected_valid", 1, 0);
      else                   check("rand_sample", sample_s, exp_q.pop_front());
    end
  endtask

  task automatic do_reset(input bit check_state);
    rst = 1'b1;
    data_in = (pat == 1) ? 1'b1 : 1'b0;
    repeat (3) @(posedge clk);
    #1;
    if (check_state) begin
      check("reset_sample", sample, 0);
      check("reset_valid", sample_valid, 0);
      check("reset_overrun", overrun, 0);
    end
    rst = 1'b0;
    cyc = -1;
  endtask

  task automatic wait_valid(input int budget, output int at);
    int n;
    n = 0;
    while (!sample_valid && n < budget) begin
      step();
      n++;
    end
    at = sample_valid ? cyc : -1;
  endtask

  task automatic run_to(input int target);
    while (cyc < target) step();
  endtask

  initial begin
    int t, t2;
    rst = 1'b1; rst_s = 1'b1; data_in = 1'b0; data_s = 1'b0;
    sample_ready = 1'b1; overrun_clr = 1'b0;
    tbl[0].pat = 1; tbl[0].exp_sample = 32767;
    tbl[1].pat = 0; tbl[1].exp_sample = -32768;
    tbl[2].pat = 2; tbl[2].exp_sample = 0;

    // Random stream on the R=16 instance; integrators wrap many times.
    pat = 0;
    repeat (3) @(posedge clk);
    #1;
    check("small_reset_valid", valid_s, 0);
    check("small_reset_sample", sample_s, 0);
    m_i1 = 0; m_i2 = 0; m_i3 = 0; m_d1 = 0; m_d2 = 0; m_d3 = 0;
    m_cnt = 0; m_warm = 0;
    rst_s = 1'b0; cyc = -1;
    mdl_upd = 1; mdl_chk = 1;
    run_to(9999);
    mdl_upd = 0;
    repeat (6) step();
    mdl_chk = 0;
    check("rand_pending", exp_q.size(), 0);
    check("rand_overrun", overrun_s, 0);
    rst_s = 1'b1;

    // Table: constant and alternating densities, ready held high.
    for (int i = 0; i < 3; i++) begin
      pat = tbl[i].pat;
      sample_ready = 1'b1;
      do_reset(i == 0);
      wait_valid(5 * R, t);
      check($sformatf("v%0d_first_cycle", i), t, 4 * R + 3);
      check($sformatf("v%0d_first_sample", i), sample, tbl[i].exp_sample);
      step();
      check($sformatf("v%0d_valid_drop", i), sample_valid, 0);
      wait_valid(R + 8, t2);
      check($sformatf("v%0d_period", i), (t2 < 0) ? -1 : t2 - t, R);
      check($sformatf("v%0d_second_sample", i), sample, tbl[i].exp_sample);
    end

    // Overrun: consumer stalls while new samples keep arriving.
    pat = 1;
    sample_ready = 1'b0;
    do_reset(0);
    wait_valid(5 * R, t);
    check("ovr_first_cycle", t, 4 * R + 3);
    check("ovr_first_sample", sample, 32767);
    pat = 0; data_in = 1'b0;
    run_to(5 * R + 2);
    check("ovr_before", overrun, 0);
    step();
    check("ovr_set", overrun, 1);
    check("ovr_valid_held", sample_valid, 1);
    run_to(8 * R + 3);
    check("ovr_newer_sample", sample, -32768);
    overrun_clr = 1'b1;
    step();
    overrun_clr = 1'b0;
    check("ovr_cleared", overrun, 0);
    run_to(9 * R + 2);
    overrun_clr = 1'b1;
    step();
    overrun_clr = 1'b0;
    check("ovr_set_wins", overrun, 1);
    overrun_clr = 1'b1;
    step();
    overrun_clr = 1'b0;
    check("ovr_cleared2", overrun, 0);
    run_to(10 * R + 2);
    sample_ready = 1'b1;
    step();
    sample_ready = 1'b0;
    check("xfer_load_no_ovr", overrun, 0);
    check("xfer_load_valid", sample_valid, 1);
    sample_ready = 1'b1;
    step();
    sample_ready = 1'b0;
    check("xfer_valid_drop", sample_valid, 0);

    // Asynchronous reset while the comb FSM is in C2 of frame 5.
    pat = 1;
    do_reset(0);
    run_to(5 * R);
    check("mid_valid_before", sample_valid, 1);
    rst = 1'b1;
    #1;
    check("mid_rst_sample", sample, 0);
    check("mid_rst_valid", sample_valid, 0);
    check("mid_rst_overrun", overrun, 0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    cyc = -1;
    wait_valid(5 * R, t);
    check("mid_first_cycle", t, 4 * R + 3);
    check("mid_first_sample", sample, 32767);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/pdm_decimator.md
# pdm_decimator

Receive-side counterpart of the `synth` 1-bit audio output. Takes the 1-bit density-modulated `data` stream at full clock rate and reconstructs signed 16-bit PCM samples with a 3rd-order CIC decimator. Samples leave through a valid/ready handshake. Used on the bench and in loop-back self-test to measure envelope, oscillator pitch and filter response numerically instead of by ear.

## Interface
- `DECIM_LOG2`, default 11: decimation ratio R = 2^DECIM_LOG2. Default R = 2048 gives 48.83 kHz at a 100 MHz clock. Legal range is 4..12.
- `OUT_W`, default 16: output sample width.
- `clk`, in, 1: system clock, single clock domain.
- `rst`, in, 1: asynchronous, active-high reset.
- `data_in`, in, 1: 1-bit stream. 1 counts as 1, 0 counts as 0 (unsigned density).
- `sample`, out, OUT_W: signed two's-complement PCM sample.
- `sample_valid`, out, 1: `sample` holds a new, unconsumed value.
- `sample_ready`, in, 1: consumer accepts `sample` this cycle.
- `overrun`, out, 1: sticky flag; a new sample was dropped while the previous one was still pending.
- `overrun_clr`, in, 1: one-cycle pulse that clears `overrun`.

## Operation
- Accumulator width W = 3*DECIM_LOG2 + 1 (34 bits at default).
- Integrators:
  - Three cascaded integrators, each W bits, updated every clock: I1 += data_in; I2 += I1; I3 += I2.
  - Arithmetic is modular and wraps silently. Integrators never saturate; correct output depends on the wrap.
- Decimation counter:
  - DECIM_LOG2 bits, free-running from 0 after reset.
  - When it equals R-1 it raises a tick; I3 is snapshotted in that same cycle, after that cycle's update.
- Comb FSM:
  - States IDLE → C1 → C2 → C3 → OUT → IDLE, one state per clock. The tick moves IDLE to C1.
  - Each Ck computes y = x − x_delayed(k) modulo 2^W and updates that stage's delay register.
- Scaling in OUT:
  - CIC result r is unsigned, 0..R^3.
  - Clamp r to R^3 − 1, take bits [W−2 : W−1−OUT_W], then invert the MSB to convert to signed.
  - Results: all-ones input gives +32767, all-zeros gives −32768, 50 % density gives 0.
- Warm-up:
  - The first 3 CIC results after reset are discarded, because the comb delays are not yet primed.
  - A 2-bit warm-up counter saturates at 3; no output is produced until it does.
- Output register and handshake:
  - Single-entry output register.
  - A transfer occurs on a cycle with `sample_valid` && `sample_ready`; `sample_valid` then drops the next cycle unless a new sample loads that same cycle.
  - On OUT with `sample_valid` = 1 and no transfer this cycle: the new sample overwrites `sample`, `sample_valid` stays 1, and `overrun` is set.
  - On OUT coinciding with a transfer: the new sample loads and there is no overrun.
  - If `overrun_clr` and a new overrun event occur in the same cycle, set wins.
- Reset:
  - All integrators, combs, counters and the FSM go to 0/IDLE.
  - `sample` = 0, `sample_valid` = 0, `overrun` = 0.
  - Reset asserted mid-frame abandons the frame and restarts warm-up.

## Timing
- Tick n occurs at clock n*R − 1, counting the first clock after reset deasserts as clock 0.
- `sample_valid` rises 4 clocks after the tick: C1, C2, C3, OUT, then the register is loaded.
- First valid sample comes from tick 4, at clock 4R + 3 (8195 at default).
- Sample period is exactly R clocks. The FSM is always idle again long before the next tick (R ≥ 16 > 5).
- `sample_ready` may be held high permanently. There is no combinational path from `sample_ready` to any output.

## Structure
- Shared package `pdm_pkg`:
  - CIC order constant (3).
  - Width function W(DECIM_LOG2).
  - Comb FSM state enum.
  - Saturation/scale function.
- Natural sub-module: `cic_integrator`, one W-bit accumulator with an input-width parameter, instantiated 3×. Comb stages, FSM and handshake stay in the top level.

## Test plan
- Constant `data_in` = 1, `sample_ready` = 1 → first `sample_valid` at clock 8195, `sample` = +32767; every later sample identical, spaced 2048 clocks apart.
- Constant 0 → samples = −32768. Alternating 1/0 → samples = 0 exactly.
- Loop-back from `synth` (trig held, `osc_count` = 66) with `DECIM_LOG2` = 8 → PCM waveform periodic at 132×2 clocks per cycle ±1 sample; peak amplitude tracks the ADSR sustain level 128/256.
- `sample_ready` held 0 across two ticks → `overrun` rises on the second OUT and `sample` holds the newer value. Pulse `overrun_clr` → `overrun` = 0. Clear and a new overrun in the same cycle → stays 1.
- Assert `rst` for 3 clocks in state C2 → all outputs 0 immediately (asynchronous); after release, first valid again at clock 4R + 3.
- Random 1-bit stream, 10 000 clocks, compared against a bit-exact model → zero mismatches, including across integrator wrap-around (checked by forcing the integrators near 2^W − 1).
